vga_fetch_scheduler: RTL and testbench
======================================

# vga_fetch_scheduler

Sequences scanline fetches from a shared single-port 16-bit frame memory into a ping-pong line buffer, timed by the `vga` timing generator's blank strobes. It also arbitrates the same memory port between display fetches and a CPU/drawing writer. It sits between `vga` and the frame memory and emits the 1 bpp pixel stream for the 640x480 mode.

## Interface
Parameters:
- `WORDS_PER_LINE`, 40: 16-pixel words per visible line.
- `LINES`, 480: visible lines per frame.
- `ADDR_W`, 15: memory word address width.

Ports:
- `clock`  in  1  sole clock.
- `reset_n`  in  1  synchronous reset, active-low.
- `vga_visible`, `vga_horizontal_blank_strobe`, `vga_vertical_blank_strobe`  in  1 each  from `vga`.
- `vga_x`  in  10  current pixel column from `vga`.
- `wr_req`  in  1  writer request; hold with address and data until `wr_ack`.
- `wr_addr`  in  ADDR_W  writer word address.
- `wr_data`  in  16  writer data.
- `wr_ack`  out  1  one-cycle pulse; the write has been accepted by memory.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  16  write data.
- `mem_ack`  in  1  one-cycle completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  16  read data.
- `pixel`  out  1  registered pixel, MSB of each word first.
- `underrun`  out  1  sticky flag: a fetch missed its deadline.

## Operation
- State machine states: IDLE, FETCH, WRITE. One memory transaction is outstanding at most.
- IDLE:
  - If a fetch is pending, go to FETCH. Fetch has priority.
  - Else if `wr_req`, go to WRITE.
- WRITE:
  - Drive `mem_req=1`, `mem_we=1`, `mem_addr=wr_addr`, `mem_wdata=wr_data`.
  - On `mem_ack`, pulse `wr_ack` and return to IDLE.
  - A fetch triggered during WRITE waits until WRITE completes.
- FETCH:
  - Drive `mem_req=1`, `mem_we=0`, `mem_addr=line_base+word`.
  - On each `mem_ack`, store `mem_rdata` to `buf[fetch_buf][word]` and increment `word`.
  - After word `WORDS_PER_LINE-1` is acked, clear pending and go to IDLE.
  - `mem_req` may stay high across consecutive words; address and data change only in the cycle after an ack.
- Fetch triggers:
  - `vga_vertical_blank_strobe`:
    - set `next_line=0`, `line_base=0`, `fetch_buf=0`, `disp_buf=0`;
    - set `armed=1`;
    - schedule a fetch of line 0.
  - `vga_horizontal_blank_strobe` when `armed`:
    - toggle `disp_buf` to the buffer just filled;
    - if `next_line < LINES-1`, increment `next_line`, add `WORDS_PER_LINE` to `line_base`, set `fetch_buf=!disp_buf`, and schedule a fetch;
    - else (last line) do not fetch.
  - `line_base` uses incremental add only; no multiplier.
- Pixel output:
  - `pixel <= armed & vga_visible & buf[disp_buf][vga_x[9:4]][15-vga_x[3:0]]`.
  - Until the first vertical blank strobe after reset, `pixel` is 0.
- Deadline:
  - A new fetch trigger arriving while a fetch is still pending sets `underrun`.
  - The old fetch is then abandoned: its remaining words are stale. The new fetch restarts at word 0.
  - If a read is in flight, the abandoned word's ack is discarded and the new fetch starts in the following cycle.
- Simultaneous hblank and vblank strobes cannot occur (vblank fires one line-end later). If they do, vblank wins.

## Timing
- Reset (`reset_n=0` at a clock edge):
  - state IDLE;
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`;
  - `wr_ack=0`, `pixel=0`, `underrun=0`;
  - `armed=0`, pending cleared, `word=0`.
- Mid-transaction reset: drop `mem_req` the next cycle and ignore any later `mem_ack`. Buffer contents are undefined.
- Strobe to first `mem_req`: 1 cycle (strobe registered, then request) when in IDLE.
- Pixel latency: `pixel` is valid one cycle after the `vga_x`/`vga_visible` sample.
- Budget: a full fetch must finish within the 200-cycle horizontal blank, which requires a mean `mem_ack` latency of 5 cycles or less per word.
- `wr_ack` occurs in the cycle after `mem_ack`. `wr_req` must drop or present a new request after `wr_ack`.

## Test plan
- Zero-latency memory (ack the cycle after req): after the vblank strobe, addresses 0..39 are read; after the first hblank strobe, addresses 40..79 are read into buffer 1. At the next visible line, `pixel` reproduces word 40 MSB-first.
- Line 479: the hblank strobe issues no read, and `mem_req` stays 0 until the vblank strobe.
- Writer collision: hold `wr_req` during a fetch. No write is issued until word 39 is acked; `wr_ack` pulses once and memory holds `wr_data` at `wr_addr`.
- Slow memory (ack latency 8): `underrun` becomes 1 at the next hblank strobe, and the fetch restarts at `line_base+0`.
- Reset asserted mid-FETCH at word 17: the next cycle shows `mem_req=0`, `pixel=0`, `underrun=0`. After release, no reads occur until a vblank strobe.
- Writer only (no strobes): 3 back-to-back writes produce 3 `wr_ack` pulses with the correct `mem_addr`/`mem_wdata` each.

Source files
------------

// File: rtl/vga_fetch_scheduler.sv
// vga_fetch_scheduler: ping-pong scanline fetch into a line buffer,
// sharing one frame-memory port with a CPU writer.
module vga_fetch_scheduler #(
  parameter int WORDS_PER_LINE = 40,
  parameter int LINES          = 480,
  parameter int ADDR_W         = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              vga_visible,
  input  logic              vga_horizontal_blank_strobe,
  input  logic              vga_vertical_blank_strobe,
  input  logic [9:0]        vga_x,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              pixel,
  output logic              underrun
);
  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam int LW = $clog2(LINES);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORDS_PER_LINE);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
  state_t state;

  logic [15:0]       lbuf [2][WORDS_PER_LINE];
  logic [LW-1:0]     next_line;
  logic [ADDR_W-1:0] line_base;
  logic [WW-1:0]     word;
  logic              fetch_buf;
  logic              disp_buf;
  logic              armed;
  logic              pending;
  logic              stale;

  logic              vs;
  logic              hs;
  logic              trig;
  logic              discard;
  logic              store;
  logic              x_ok;
  logic [ADDR_W-1:0] base_eff;
  logic [WW-1:0]     x_word;
  logic [3:0]        bit_sel;

  always_comb begin
    vs       = vga_vertical_blank_strobe;
    hs       = vga_horizontal_blank_strobe & armed & ~vs;
    trig     = vs | (hs & (next_line < LAST_LINE));
    base_eff = line_base;
    if (vs)
      base_eff = '0;
    else if (trig)
      base_eff = line_base + STEP;
    // an ack racing a new trigger belongs to the abandoned line
    discard  = (state == FETCH) & mem_ack & (stale | trig);
    store    = (state == FETCH) & mem_ack & ~discard;
    x_ok     = int'(vga_x[9:4]) < WORDS_PER_LINE;
    x_word   = WW'(vga_x[9:4]);
    bit_sel  = 4'd15 - vga_x[3:0];
  end

  always_ff @(posedge clock) begin
    if (store)
      lbuf[fetch_buf][word] <= mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      pixel     <= 1'b0;
      underrun  <= 1'b0;
      armed     <= 1'b0;
      pending   <= 1'b0;
      stale     <= 1'b0;
      word      <= '0;
      next_line <= '0;
      line_base <= '0;
      fetch_buf <= 1'b0;
      disp_buf  <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      pixel  <= armed & vga_visible & x_ok &
                lbuf[disp_buf][x_word][bit_sel];
      if (vs) begin
        next_line <= '0;
        line_base <= '0;
        fetch_buf <= 1'b0;
        disp_buf  <= 1'b0;
        armed     <= 1'b1;
      end else if (hs) begin
        disp_buf <= fetch_buf;
        if (trig) begin
          next_line <= next_line + 1'b1;
          line_base <= base_eff;
          fetch_buf <= ~fetch_buf;
        end
      end
      if (trig & pending)
        underrun <= 1'b1;
      if (trig)
        pending <= 1'b1;
      else if (store && word == LAST_WORD)
        pending <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pending) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= base_eff;
          end else if (wr_req) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            wr_ack  <= 1'b1;
          end
        end
        FETCH: begin
          if (trig & ~mem_ack)
            stale <= 1'b1;
          if (discard) begin
            stale    <= 1'b0;
            word     <= '0;
            mem_addr <= base_eff;
          end else if (store) begin
            if (word == LAST_WORD) begin
              state   <= IDLE;
              mem_req <= 1'b0;
              word    <= '0;
            end else begin
              word     <= word + 1'b1;
              mem_addr <= line_base + ADDR_W'(word) + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// tb_vga_fetch_scheduler: random frame memory, writer and deadline
// stimulus against a line-level model of the fetch scheduler.
module tb_vga_fetch_scheduler;
  localparam int WPL   = 40;
  localparam int LINES = 480;
  localparam int AW    = 15;
  localparam int FRAME = WPL * LINES;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          vga_visible = 1'b0;
  logic          vga_horizontal_blank_strobe = 1'b0;
  logic          vga_vertical_blank_strobe = 1'b0;
  logic [9:0]    vga_x = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          wr_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_rdata = '0;
  logic          pixel;
  logic          underrun;

  always #5 clock = ~clock;

  vga_fetch_scheduler dut (
    .clock                       (clock),
    .reset_n                     (reset_n),
    .vga_visible                 (vga_visible),
    .vga_horizontal_blank_strobe (vga_horizontal_blank_strobe),
    .vga_vertical_blank_strobe   (vga_vertical_blank_strobe),
    .vga_x                       (vga_x),
    .wr_req                      (wr_req),
    .wr_addr                     (wr_addr),
    .wr_data                     (wr_data),
    .wr_ack                      (wr_ack),
    .mem_req                     (mem_req),
    .mem_we                      (mem_we),
    .mem_addr                    (mem_addr),
    .mem_wdata                   (mem_wdata),
    .mem_ack                     (mem_ack),
    .mem_rdata                   (mem_rdata),
    .pixel                       (pixel),
    .underrun                    (underrun)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } txn_t;

  logic [15:0] fmem [0:(1<<AW)-1];
  txn_t        log_q[$];
  txn_t        mt;
  int          exp_q[$];
  int          lat = 1;
  int          mcnt = 0;
  bit          track = 0;
  int          rd_total = 0;
  int          rd_bad = 0;
  int          wr_ack_cnt = 0;
  int          req_hi_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // line-level model state
  bit          armed_m = 0;
  int          fetch_line = 0;
  int          disp_line = 0;

  // frame memory with a fixed ack latency, responding on the negedge
  always @(negedge clock) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (mcnt + 1 >= lat) begin
        mcnt = 0;
        mem_ack = 1'b1;
        mt.we = mem_we;
        mt.addr = mem_addr;
        if (mem_we) begin
          fmem[mem_addr] = mem_wdata;
          mt.data = mem_wdata;
        end else begin
          mem_rdata = fmem[mem_addr];
          mt.data = fmem[mem_addr];
        end
        log_q.push_back(mt);
        if (track && !mem_we) begin
          rd_total++;
          if (exp_q.size() == 0) rd_bad++;
          else if (exp_q.pop_front() != int'(mem_addr)) rd_bad++;
        end
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
    end
    if (wr_ack) wr_ack_cnt++;
    if (mem_req) req_hi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_line(input int ln);
    if (track)
      for (int i = 0; i < WPL; i++) exp_q.push_back(ln * WPL + i);
  endtask

  task automatic vblank();
    vga_vertical_blank_strobe = 1'b1;
    @(negedge clock);
    vga_vertical_blank_strobe = 1'b0;
    armed_m = 1;
    fetch_line = 0;
    disp_line = 0;
    push_line(0);
  endtask

  task automatic hblank();
    vga_horizontal_blank_strobe = 1'b1;
    @(negedge clock);
    vga_horizontal_blank_strobe = 1'b0;
    if (armed_m) begin
      disp_line = fetch_line;
      if (fetch_line < LINES - 1) begin
        fetch_line++;
        push_line(fetch_line);
      end
    end
  endtask

  task automatic probe(input int n, input string tag);
    int x;
    bit v;
    logic [15:0] w;
    logic e;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(639);
      v = 1'($urandom_range(1));
      vga_x = 10'(x);
      vga_visible = v;
      @(negedge clock);
      w = fmem[disp_line * WPL + x / 16];
      e = armed_m & v & w[15 - x % 16];
      check(tag, pixel, e);
    end
    vga_visible = 1'b0;
  endtask

  task automatic do_writes(input int n, input int lo, input int hi,
                           input string tag, output int first_w);
    logic [AW-1:0] a[$];
    logic [15:0] d[$];
    int base, done, waited, c0, nw;
    base = $urandom_range(hi - n, lo);
    for (int i = 0; i < n; i++) begin
      a.push_back(AW'(base + i));
      d.push_back(16'($urandom));
    end
    c0 = wr_ack_cnt;
    wr_req = 1'b1;
    wr_addr = a[0];
    wr_data = d[0];
    done = 0;
    waited = 0;
    while (done < n && waited < 400) begin
      @(negedge clock);
      waited++;
      if (wr_ack) begin
        done++;
        if (done < n) begin
          wr_addr = a[done];
          wr_data = d[done];
        end else begin
          wr_req = 1'b0;
        end
      end
    end
    wr_req = 1'b0;
    check({tag, "_acked"}, done, n);
    tick(3);
    check({tag, "_ack_pulses"}, wr_ack_cnt - c0, n);
    first_w = -1;
    nw = 0;
    for (int k = 0; k < log_q.size(); k++) begin
      if (log_q[k].we) begin
        if (first_w < 0) first_w = k;
        if (nw < n) begin
          check({tag, "_addr"}, log_q[k].addr, a[nw]);
          check({tag, "_wdata"}, log_q[k].data, d[nw]);
        end
        nw++;
      end
    end
    check({tag, "_count"}, nw, n);
    for (int i = 0; i < n; i++)
      check({tag, "_mem"}, fmem[a[i]], d[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fw, bad, w0, w1, idx, waited, c0, pa, pb;
    logic [15:0] w40;
    for (int i = 0; i < (1 << AW); i++) fmem[i] = 16'($urandom);
    pa = $urandom_range(200, 4);
    pb = $urandom_range(470, 201);

    tick(4);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_pixel", pixel, 0);
    check("rst_underrun", underrun, 0);
    reset_n = 1'b1;
    tick(2);
    probe(8, "pix_unarmed");

    // full frame with single-cycle memory
    track = 1;
    vblank();
    tick(100);
    for (int k = 1; k <= LINES; k++) begin
      hblank();
      if (k == 1) begin
        log_q.delete();
        tick(10);
        do_writes(1, FRAME, (1 << AW) - 1, "collide", fw);
        check("collide_after_fetch", fw, WPL);
        bad = 0;
        for (int i = 0; i < WPL; i++)
          if (i >= log_q.size() || log_q[i].we ||
              int'(log_q[i].addr) != WPL + i) bad++;
        check("line1_addrs", bad, 0);
        tick(10);
      end else if (k == 2) begin
        w40 = fmem[WPL];
        for (int i = 0; i < 16; i++) begin
          vga_x = 10'(i);
          vga_visible = 1'b1;
          @(negedge clock);
          check("word40_bit", pixel, w40[15 - i]);
        end
        vga_visible = 1'b0;
        tick(84);
      end else if (k == 3 || k == pa || k == pb) begin
        probe(20, "pix_line");
        tick(80);
      end else if (k == LINES) begin
        c0 = req_hi_cnt;
        probe(20, "pix_last");
        tick(180);
        check("no_req_after_last", req_hi_cnt - c0, 0);
      end else begin
        tick(99);
      end
    end
    check("frame_reads", rd_total, FRAME);
    check("frame_bad_addrs", rd_bad, 0);
    check("frame_exp_left", exp_q.size(), 0);
    track = 0;

    // slow memory misses the deadline
    lat = 8;
    vblank();
    tick(100);
    check("ur_before", underrun, 0);
    log_q.delete();
    hblank();
    check("ur_set", underrun, 1);
    tick(45);
    idx = (log_q.size() > 0 && int'(log_q[0].addr) < WPL) ? 1 : 0;
    w0 = (log_q.size() > idx) ? int'(log_q[idx].addr) : -1;
    w1 = (log_q.size() > idx + 1) ? int'(log_q[idx + 1].addr) : -1;
    check("ur_restart_addr", w0, WPL);
    check("ur_next_addr", w1, WPL + 1);

    // reset in the middle of a line fetch
    lat = 1;
    vblank();
    vga_visible = 1'b1;
    vga_x = 10'($urandom_range(639));
    waited = 0;
    while (!(mem_req && mem_addr == AW'(17)) && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    check("reach_word17", waited < 300, 1);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_pixel", pixel, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_mem_addr", mem_addr, 0);
    vga_visible = 1'b0;
    armed_m = 0;
    tick(2);
    reset_n = 1'b1;
    @(negedge clock);
    log_q.delete();
    c0 = req_hi_cnt;
    tick(100);
    check("post_rst_reads", log_q.size(), 0);
    check("post_rst_req", req_hi_cnt - c0, 0);
    probe(10, "pix_post_rst");

    // writer only, back to back
    log_q.delete();
    do_writes(3, 0, (1 << AW) - 1, "wr_only", fw);
    check("wr_only_first", fw, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
